// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search
//  Description : Successive-approximation search controller. Drives the B
//                operand of an external magnitude comparator with `guess`
//                and narrows [lo, hi] from the comparator's one-hot
//                {gt, eq, lt} result, recovering the unknown A operand with
//                one probe per clock.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                start  - request a new search (honoured only when idle)
//                cmp    - comparator result {A>guess, A==guess, A<guess}
//                guess  - current probe value (combinational from lo/hi)
//                busy   - search in progress
//                done   - one-cycle pulse when a search terminates
//                result - recovered A value, valid when found is high
//                found  - last search terminated on eq
//                err    - last search terminated on a non-one-hot cmp
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_search #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   cmp,
    output logic [W-1:0] guess,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         found,
    output logic         err
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } state_t;

    localparam logic [W-1:0] c_one = W'(1);

    state_t         r_state;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_result;
    logic           r_found;
    logic           r_err;
    logic           r_done;

    logic [W:0]     w_sum;
    logic [W-1:0]   w_guess;

    // Midpoint is taken on a W+1 bit sum so lo+hi never wraps.
    assign w_sum   = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_guess = W'(w_sum >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_result <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lo     <= '0;
                        r_hi     <= '1;
                        r_result <= '0;
                        r_found  <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    case (cmp)
                        3'b010: begin
                            r_result <= w_guess;
                            r_found  <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                        3'b100: begin
                            // guess==hi with A still above it means the
                            // comparator is inconsistent; stop rather than
                            // push lo past the top of the range.
                            if (w_guess == r_hi) begin
                                r_found <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_lo <= w_guess + c_one;
                            end
                        end
                        3'b001: begin
                            // Mirror guard: keeps hi from underflowing.
                            if (w_guess == r_lo) begin
                                r_found <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_hi <= w_guess - c_one;
                            end
                        end
                        default: begin
                            r_err   <= 1'b1;
                            r_found <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign guess  = w_guess;
    assign busy   = (r_state == S_SEARCH);
    assign done   = r_done;
    assign result = r_result;
    assign found  = r_found;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller that drives the B operand of an external magnitude comparator and consumes its one-hot {gt, eq, lt} result. It binary-searches the unsigned range [0, 2^W−1] to recover the unknown A operand, one probe per clock. It sits upstream of the existing 4-bit comparator: its `guess` feeds B, and the comparator's R vector feeds `cmp`.

## Interface
- W, default 4: operand width. Search range is 0..2^W−1; at most W+1 probes per search.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new search; honoured only in IDLE.
- cmp  input  3  comparator result for the current `guess`: bit2 = A>guess, bit1 = A==guess, bit0 = A<guess; must be one-hot.
- guess  output  W  current probe value, driven to the comparator B input.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when a search terminates.
- result  output  W  recovered A value; valid when `found` is high.
- found  output  1  the last search terminated on eq.
- err  output  1  the last search terminated on a non-one-hot `cmp`.

## Operation
- State registers: lo, hi (W bits each), FSM {IDLE, SEARCH}. Output registers: result, found, err, done.
- guess = (lo + hi) >> 1, with the sum computed at W+1 bits (no overflow). guess is combinational from lo/hi.
- IDLE: if start, then lo←0, hi←2^W−1, result←0, found←0, err←0, go to SEARCH. Otherwise hold everything.
- SEARCH, evaluated on each clock edge using `cmp`:
  - cmp not one-hot (000, 011, 101, 110, 111): err←1, found←0, done pulse, go to IDLE; lo/hi hold.
  - eq (010): result←guess, found←1, done pulse, go to IDLE.
  - gt (100): if guess==hi, then found←0, done pulse, go to IDLE (inconsistent comparator); else lo←guess+1.
  - lt (001): if guess==lo, then found←0, done pulse, go to IDLE; else hi←guess−1.
- The guess==lo / guess==hi guards prevent underflow and overflow of lo/hi. A consistent comparator never triggers them.
- start while busy is ignored. start is a level input sampled only in IDLE.
- result, found and err hold after done until the next accepted start, which clears them.

## Timing
- Reset (async, rst_n=0): FSM=IDLE; lo=0, hi=0 (so guess=0); busy=0, done=0, result=0, found=0, err=0.
- start sampled high at edge 0 gives busy=1 from edge 0. Probe 1 is presented during the cycle after edge 0. Probe n's `cmp` is sampled at edge n.
- For a search that terminates on probe N: busy falls at edge N, done is high for exactly the cycle after edge N, and result/found/err are valid from edge N.
- Latency from start to done is N+1 edges. N ≤ W+1; for W=4, N ≤ 5.
- `cmp` must settle combinationally within the cycle in which guess is presented. There is no pipelining inside the block.
- start high in the done cycle (FSM already IDLE) is accepted at the next edge, so back-to-back searches run with no idle gap.
- rst_n asserted mid-search aborts immediately to reset values. No done pulse is produced.

## Test plan
- W=4, comparator model with A=9; pulse start. Required: guess sequence 7, 11, 9; done in the cycle after edge 3; result=9, found=1, err=0.
- A=15. Required: guess sequence 7, 11, 13, 14, 15 (5 probes); result=15, found=1. A=0 separately. Required: guess sequence 7, 3, 1, 0; result=0, found=1.
- Force cmp=001 on every probe. Required: guess sequence 7, 3, 1, 0; at the guess==lo guard, done pulses with found=0, err=0, and there is no hi underflow.
- Force cmp=000 on the first probe. Required: done in the cycle after edge 1, err=1, found=0. A following start clears err to 0.
- Sweep A=0..15 with back-to-back starts (start held high). Required: every result equals A, each search takes ≤5 probes, and start pulses during busy do not perturb the sequence.
- Drop rst_n during probe 2 of an A=12 search. Required: all outputs go to reset values asynchronously with no done pulse; after release, a new start recovers result=12.
